// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sign-magnitude multiply sequencer:
//   OP_W      - operand width handled by the absolute_value datapath
//   PROD_W    - width of the signed product
//   state_e   - sequencer states (IDLE, ABS_A, ABS_B, MUL, SIGN, DONE)
//   applySign - turns an unsigned magnitude back into a signed product
// Optional feature macro used by the importers: ZERO_SKIP_EN.
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS_A = 3'd1,
    ABS_B = 3'd2,
    MUL   = 3'd3,
    SIGN  = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Negation is skipped for a zero magnitude so the result is always +0.
  function automatic logic [PROD_W-1:0] applySign(input logic neg,
                                                  input logic [PROD_W-1:0] mag);
    logic [PROD_W-1:0] result;
    result = mag;
    if (neg && (mag != '0)) begin
      result = (~mag) + PROD_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/absolute_value.sv
// ---------------------------------------------------------------------------
// absolute_value
// Combinational magnitude of an 8-bit two's-complement value.
// Ports:
//   a_i [OP_W-1:0]  signed input
//   s_o [OP_W-1:0]  unsigned magnitude; 8'h80 (-128) yields 8'h80 (128)
// The carry out of the conditional negate carries no information for the
// sequencer, so it is not brought out as a port.
// ---------------------------------------------------------------------------
module absolute_value
  import mult_pkg::*;
(
  input  logic [OP_W-1:0] a_i,
  output logic [OP_W-1:0] s_o
);

  // Conditional two's-complement negate; the top bit of the input selects it.
  // For -128 the negate wraps back to 8'h80, which read as unsigned is 128.
  always_comb begin
    s_o = a_i;
    if (a_i[OP_W-1]) begin
      s_o = (~a_i) + OP_W'(1);
    end
  end

endmodule

// File: rtl/signed_mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// signed_mult_seq_ctrl
// Sequencer for the shared sign-magnitude multiply path. One operand pair is
// accepted over a valid/ready handshake, each operand's magnitude is taken
// through one time-shared absolute_value instance, a WIDTH-cycle shift-add
// loop builds the magnitude product, the sign is restored and the signed
// product is returned over a second valid/ready handshake.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair valid
//   in_ready   pair can be accepted (only in IDLE)
//   a, b       signed multiplicand / multiplier, WIDTH bits
//   out_valid  product valid (DONE state)
//   out_ready  consumer accepts the product
//   product    signed 2*WIDTH result, held stable while out_valid is high
//   busy       high in every state except IDLE
// Optional feature macro: ZERO_SKIP_EN - when defined, a zero magnitude on
// either operand bypasses MUL and SIGN and goes straight to DONE with 0.
// ---------------------------------------------------------------------------
module signed_mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  // The magnitude path is the fixed 8-bit absolute_value block, so any other
  // operand width cannot be built.
  if (WIDTH != OP_W) begin : gWidthCheck
    $error("signed_mult_seq_ctrl: WIDTH must equal OP_W (8)");
  end

  state_e               state_q,   state_d;
  logic [WIDTH-1:0]     aReg_q,    aReg_d;
  logic [WIDTH-1:0]     bReg_q,    bReg_d;
  logic                 sign_q,    sign_d;
  logic [WIDTH-1:0]     magA_q,    magA_d;
  logic [WIDTH-1:0]     magB_q,    magB_d;
  logic [2*WIDTH-1:0]   acc_q,     acc_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     absIn;
  logic [WIDTH-1:0]     absOut;

  // One magnitude unit shared by both operands; the FSM steers a_reg into it
  // during ABS_A and b_reg during ABS_B.
  absolute_value uAbs (
    .a_i (absIn),
    .s_o (absOut)
  );

  // State and datapath registers. A synchronous reset returns everything to
  // zero, which also abandons any transaction in flight without an output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aReg_q    <= '0;
      bReg_q    <= '0;
      sign_q    <= 1'b0;
      magA_q    <= '0;
      magB_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      aReg_q    <= aReg_d;
      bReg_q    <= bReg_d;
      sign_q    <= sign_d;
      magA_q    <= magA_d;
      magB_q    <= magB_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath control. Every register holds by default so only
  // the state that owns a register has to mention it. In MUL, bit cnt of the
  // multiplier magnitude gates adding the multiplicand shifted by cnt; the
  // last of the WIDTH iterations happens on the cycle that leaves for SIGN.
  always_comb begin
    state_d   = state_q;
    aReg_d    = aReg_q;
    bReg_d    = bReg_q;
    sign_d    = sign_q;
    magA_d    = magA_q;
    magB_d    = magB_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    absIn     = aReg_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          aReg_d  = a;
          bReg_d  = b;
          sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
          state_d = ABS_A;
        end
      end

      ABS_A: begin
        absIn   = aReg_q;
        magA_d  = absOut;
        state_d = ABS_B;
      end

      ABS_B: begin
        absIn   = bReg_q;
        magB_d  = absOut;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = MUL;
`ifdef ZERO_SKIP_EN
        if ((magA_q == '0) || (absOut == '0)) begin
          product_d = '0;
          state_d   = DONE;
        end
`endif
      end

      MUL: begin
        if (magB_q[cnt_q[CNT_W-2:0]]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, magA_q} << cnt_q);
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = SIGN;
        end
      end

      SIGN: begin
        product_d = applySign(sign_q, acc_q);
        state_d   = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and status outputs decode directly from the state register so
  // they are glitch-free and stable across backpressure.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

endmodule
